// File: rtl/ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package ring_arbiter_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Widest ring the helper functions handle.
    localparam int unsigned MAX_REQ = 32;
    localparam int unsigned IDX_W   = 5;

    // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (v[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Rotate the low n bits of v left by one, bit n-1 wrapping to bit 0.
    function automatic logic [MAX_REQ-1:0] rotl1(input logic [MAX_REQ-1:0] v, input int n);
        logic [MAX_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (i < n - 1) begin
                r[i+1] = v[i];
            end else if (i == n - 1) begin
                r[0] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req at or above the one-hot ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 8
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] ptr,
    output logic [NREQ-1:0] winner
);

    localparam int unsigned DW = 2 * NREQ;

    logic [NREQ-1:0] w_above;
    logic [DW-1:0]   w_dbl;
    logic [DW-1:0]   w_iso;

    // Lower half holds requests at/above ptr, upper half the full set for wrap-around;
    // isolating the lowest set bit of the concatenation gives the ring-order winner.
    always_comb begin
        w_above = ~(ptr - NREQ'(1));
        w_dbl   = {req, req & w_above};
        w_iso   = w_dbl & (~w_dbl + DW'(1));
        winner  = w_iso[NREQ-1:0] | w_iso[DW-1:NREQ];
    end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin ring arbiter with one-hot rotating priority and a one-cycle turnaround.
// Optional grant timeout enabled by defining RING_ARBITER_TIMEOUT_EN.
module ring_arbiter
    import ring_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 8,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [NREQ-1:0]         req,
    input  logic                    ptr_ld,
    input  logic [NREQ-1:0]         ptr_d,
    output logic [NREQ-1:0]         gnt,
    output logic                    gnt_v,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic [NREQ-1:0]         ptr,
    output logic                    tmo
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TMO_CYCLES + 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [NREQ-1:0] r_ptr;
    logic [NREQ-1:0] w_ptr_nxt;
    logic [NREQ-1:0] w_win;
    logic            w_own_req;
    logic [NREQ-1:0] w_rel_ptr;

`ifdef RING_ARBITER_TIMEOUT_EN
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_tmo;
    logic            w_tmo_nxt;
`else
    logic [TW-1:0]   w_unused_tmo_cycles;
    assign w_unused_tmo_cycles = TW'(TMO_CYCLES);
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_win)
    );

    assign w_own_req = |(req & r_gnt);
    assign w_rel_ptr = NREQ'(rotl1(MAX_REQ'(r_gnt), int'(NREQ)));

    // Next-state, grant, pointer and timer decisions; everything holds when ce is low.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
`ifdef RING_ARBITER_TIMEOUT_EN
        w_timer_nxt = r_timer;
        w_tmo_nxt   = 1'b0;
`endif
        if (ce) begin
            case (r_state)
                IDLE: begin
                    if (ptr_ld && $onehot(ptr_d)) begin
                        w_ptr_nxt = ptr_d;
                    end
                    if (|req) begin
                        w_gnt_nxt   = w_win;
                        w_state_nxt = GRANT;
`ifdef RING_ARBITER_TIMEOUT_EN
                        w_timer_nxt = TW'(1);
`endif
                    end else begin
                        w_gnt_nxt = '0;
                    end
                end
                GRANT: begin
                    if (!w_own_req) begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = w_rel_ptr;
`ifdef RING_ARBITER_TIMEOUT_EN
                        w_timer_nxt = '0;
                    end else if (r_timer == TW'(TMO_CYCLES)) begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = w_rel_ptr;
                        w_timer_nxt = '0;
                        w_tmo_nxt   = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
`endif
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, grant and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= NREQ'(1);
`ifdef RING_ARBITER_TIMEOUT_EN
            r_timer <= '0;
            r_tmo   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef RING_ARBITER_TIMEOUT_EN
            r_timer <= w_timer_nxt;
            r_tmo   <= w_tmo_nxt;
`endif
        end
    end

    assign gnt     = r_gnt;
    assign ptr     = r_ptr;
    assign gnt_v   = |r_gnt;
    assign gnt_idx = IW'(onehot_to_idx(MAX_REQ'(r_gnt)));

`ifdef RING_ARBITER_TIMEOUT_EN
    assign tmo = r_tmo;
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed-vector bench for ring_arbiter (NREQ=8, TMO_CYCLES=4).
module tb_ring_arbiter;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [7:0] req;
    logic       ptr_ld;
    logic [7:0] ptr_d;
    logic [7:0] gnt;
    logic       gnt_v;
    logic [2:0] gnt_idx;
    logic [7:0] ptr;
    logic       tmo;

    int n_vec;
    int n_bad;

    ring_arbiter #(.NREQ(8), .TMO_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .req     (req),
        .ptr_ld  (ptr_ld),
        .ptr_d   (ptr_d),
        .gnt     (gnt),
        .gnt_v   (gnt_v),
        .gnt_idx (gnt_idx),
        .ptr     (ptr),
        .tmo     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_g;
        n_vec  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        ce     = 1'b1;
        req    = '0;
        ptr_ld = 1'b0;
        ptr_d  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_gnt_v", 32'(gnt_v), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h01);
        chk("rst_tmo", 32'(tmo), 32'h0);

        // single requester grant and release
        req = 8'h01;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h01);
        chk("t1_gnt_v", 32'(gnt_v), 32'h1);
        req = 8'h00;
        tick();
        chk("t1_rel_gnt", 32'(gnt), 32'h00);
        chk("t1_rel_ptr", 32'(ptr), 32'h02);

        // full ring rotation, each owner holds two cycles
        ptr_ld = 1'b1;
        ptr_d  = 8'h01;
        tick();
        ptr_ld = 1'b0;
        chk("t2_ld_ptr", 32'(ptr), 32'h01);
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            tick();
            chk("t2_gnt", 32'(gnt), 32'(exp_g));
            chk("t2_idx", 32'(gnt_idx), 32'(k % 8));
            tick();
            chk("t2_hold", 32'(gnt), 32'(exp_g));
            req = 8'hFF & ~exp_g;
            tick();
            chk("t2_gap", 32'(gnt), 32'h00);
            chk("t2_ptr", 32'(ptr), 32'(8'h01 << ((k + 1) % 8)));
            req = 8'hFF;
        end
        req = 8'h00;
        tick();
        chk("t2_idle", 32'(gnt), 32'h00);

        // wrap-around pick
        ptr_ld = 1'b1;
        ptr_d  = 8'h10;
        tick();
        ptr_ld = 1'b0;
        chk("t3_ptr", 32'(ptr), 32'h10);
        req = 8'h06;
        tick();
        chk("t3_gnt", 32'(gnt), 32'h02);
        chk("t3_idx", 32'(gnt_idx), 32'h1);
        req = 8'h00;
        tick();
        chk("t3_rel_gnt", 32'(gnt), 32'h00);
        chk("t3_rel_ptr", 32'(ptr), 32'h04);

        // pointer load rules
        ptr_ld = 1'b1;
        ptr_d  = 8'h20;
        tick();
        chk("t4_ld", 32'(ptr), 32'h20);
        ptr_d = 8'h30;
        tick();
        chk("t4_nonhot", 32'(ptr), 32'h20);
        ptr_ld = 1'b0;
        req    = 8'h01;
        tick();
        chk("t4_gnt", 32'(gnt), 32'h01);
        ptr_ld = 1'b1;
        ptr_d  = 8'h80;
        tick();
        ptr_ld = 1'b0;
        chk("t4_ld_grant", 32'(ptr), 32'h20);
        chk("t4_gnt_hold", 32'(gnt), 32'h01);

        // clock enable freeze while owner drops
        ce  = 1'b0;
        req = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_frz_gnt", 32'(gnt), 32'h01);
            chk("t5_frz_ptr", 32'(ptr), 32'h20);
        end
        ce = 1'b1;
        tick();
        chk("t5_rel_gnt", 32'(gnt), 32'h00);
        chk("t5_rel_ptr", 32'(ptr), 32'h02);

        // load and arbitrate on the same edge: old pointer decides
        req    = 8'h81;
        ptr_ld = 1'b1;
        ptr_d  = 8'h01;
        tick();
        ptr_ld = 1'b0;
        chk("t7_gnt", 32'(gnt), 32'h80);
        chk("t7_idx", 32'(gnt_idx), 32'h7);
        chk("t7_ptr", 32'(ptr), 32'h01);
        req = 8'h00;
        tick();
        chk("t7_rel_ptr", 32'(ptr), 32'h01);

        // long hold of req[3]
        req = 8'h08;
`ifdef RING_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_gnt", 32'(gnt), 32'h08);
            chk("t6_tmo_lo", 32'(tmo), 32'h0);
        end
        tick();
        chk("t6_tmo_gnt", 32'(gnt), 32'h00);
        chk("t6_tmo", 32'(tmo), 32'h1);
        chk("t6_tmo_ptr", 32'(ptr), 32'h10);
        tick();
        chk("t6_tmo_end", 32'(tmo), 32'h0);
        chk("t6_regnt", 32'(gnt), 32'h08);
`else
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t6_hold", 32'(gnt), 32'h08);
            chk("t6_tmo", 32'(tmo), 32'h0);
        end
`endif
        req = 8'h00;
        tick();
        chk("t6_rel_gnt", 32'(gnt), 32'h00);
        chk("t6_rel_ptr", 32'(ptr), 32'h10);

        // reset mid-grant
        req = 8'h04;
        tick();
        chk("t8_gnt", 32'(gnt), 32'h04);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h00;
        chk("t8_rst_gnt", 32'(gnt), 32'h00);
        chk("t8_rst_gnt_v", 32'(gnt_v), 32'h0);
        chk("t8_rst_ptr", 32'(ptr), 32'h01);
        tick();
        chk("t8_idle", 32'(gnt), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
